// File: rtl/decode_cycle.sv
`default_nettype none
// ============================================================================
// Module   : decode_cycle
// Purpose  : RV32I decode stage - control decode, register file with
//            write-through, immediate extension and the D/E pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module decode_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] c_opLw    = 7'b0000011;
    localparam logic [6:0] c_opSw    = 7'b0100011;
    localparam logic [6:0] c_opRtype = 7'b0110011;
    localparam logic [6:0] c_opBeq   = 7'b1100011;
    localparam logic [6:0] c_opIalu  = 7'b0010011;
    localparam logic [6:0] c_opJal   = 7'b1101111;

    logic [XLEN-1:0] r_regFile [32];

    logic [6:0]      w_op;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_regWrite;
    logic [1:0]      w_immSrc;
    logic            w_aluSrc;
    logic            w_memWrite;
    logic [1:0]      w_resultSrc;
    logic            w_branch;
    logic [1:0]      w_aluOp;
    logic            w_jump;
    logic [2:0]      w_aluControl;
    logic [XLEN-1:0] w_immExt;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign w_op     = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_rs1    = InstrD[19:15];
    assign w_rs2    = InstrD[24:20];

    always_comb begin
        w_regWrite  = 1'b0;
        w_immSrc    = 2'b00;
        w_aluSrc    = 1'b0;
        w_memWrite  = 1'b0;
        w_resultSrc = 2'b00;
        w_branch    = 1'b0;
        w_aluOp     = 2'b00;
        w_jump      = 1'b0;
        case (w_op)
            c_opLw: begin
                w_regWrite  = 1'b1;
                w_aluSrc    = 1'b1;
                w_resultSrc = 2'b01;
            end
            c_opSw: begin
                w_immSrc   = 2'b01;
                w_aluSrc   = 1'b1;
                w_memWrite = 1'b1;
            end
            c_opRtype: begin
                w_regWrite = 1'b1;
                w_aluOp    = 2'b10;
            end
            c_opBeq: begin
                w_immSrc = 2'b10;
                w_branch = 1'b1;
                w_aluOp  = 2'b01;
            end
            c_opIalu: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_aluOp    = 2'b10;
            end
            c_opJal: begin
                w_regWrite  = 1'b1;
                w_immSrc    = 2'b11;
                w_resultSrc = 2'b10;
                w_jump      = 1'b1;
            end
            default: ;
        endcase
    end

    // op[5] separates R-type from I-ALU so that addi with imm[10] set never subtracts
    always_comb begin
        w_aluControl = 3'b000;
        case (w_aluOp)
            2'b01: w_aluControl = 3'b001;
            2'b10: begin
                case (w_funct3)
                    3'b000:  w_aluControl = (w_op[5] & InstrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  w_aluControl = 3'b101;
                    3'b110:  w_aluControl = 3'b011;
                    3'b111:  w_aluControl = 3'b010;
                    default: w_aluControl = 3'b000;
                endcase
            end
            default: w_aluControl = 3'b000;
        endcase
    end

    always_comb begin
        w_immExt = '0;
        case (w_immSrc)
            2'b00: w_immExt = {{20{InstrD[31]}}, InstrD[31:20]};
            2'b01: w_immExt = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10: w_immExt = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            2'b11: w_immExt = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: w_immExt = '0;
        endcase
    end

    // Write-through so a W-stage result is visible to the instruction decoding this cycle
    always_comb begin
        w_rd1 = r_regFile[w_rs1];
        w_rd2 = r_regFile[w_rs2];
        if (RegWriteW && (RDW != 5'd0) && (RDW == w_rs1)) w_rd1 = ResultW;
        if (RegWriteW && (RDW != 5'd0) && (RDW == w_rs2)) w_rd2 = ResultW;
        if (w_rs1 == 5'd0) w_rd1 = '0;
        if (w_rs2 == 5'd0) w_rd2 = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regFile[i] <= '0;
        end else if (RegWriteW && (RDW != 5'd0)) begin
            r_regFile[RDW] <= ResultW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= w_regWrite;
            ResultSrcE  <= w_resultSrc;
            MemWriteE   <= w_memWrite;
            JumpE       <= w_jump;
            BranchE     <= w_branch;
            ALUControlE <= w_aluControl;
            ALUSrcE     <= w_aluSrc;
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ImmExtE     <= w_immExt;
            Rs1E        <= w_rs1;
            Rs2E        <= w_rs2;
            RdE         <= InstrD[11:7];
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_cycle
// Purpose  : Directed self-checking bench for decode_cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int checkCount = 0;
    int errorCount = 0;

    decode_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkControls(input string tag, input logic [31:0] regWr,
                                 input logic [31:0] resSrc, input logic [31:0] memWr,
                                 input logic [31:0] jmp, input logic [31:0] br,
                                 input logic [31:0] aluCtl, input logic [31:0] aluSrc);
        checkVal({tag, ".RegWriteE"},   {31'd0, RegWriteE},   regWr);
        checkVal({tag, ".ResultSrcE"},  {30'd0, ResultSrcE},  resSrc);
        checkVal({tag, ".MemWriteE"},   {31'd0, MemWriteE},   memWr);
        checkVal({tag, ".JumpE"},       {31'd0, JumpE},       jmp);
        checkVal({tag, ".BranchE"},     {31'd0, BranchE},     br);
        checkVal({tag, ".ALUControlE"}, {29'd0, ALUControlE}, aluCtl);
        checkVal({tag, ".ALUSrcE"},     {31'd0, ALUSrcE},     aluSrc);
    endtask

    initial begin
        rst = 1'b1; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; FlushE = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Write x5 while decoding addi so the outputs are non-zero before reset
        InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h55;
        tick();
        RegWriteW = 1'b0;
        checkVal("pre_rst.ImmExtE", ImmExtE, 32'd5);
        rst = 1'b1;
        tick();
        checkControls("rst", 0, 0, 0, 0, 0, 0, 0);
        checkVal("rst.ImmExtE", ImmExtE, 32'h0);
        checkVal("rst.RdE", {27'd0, RdE}, 32'h0);
        checkVal("rst.PCE", PCE, 32'h0);
        checkVal("rst.PCPlus4E", PCPlus4E, 32'h0);
        rst = 1'b0;
        InstrD = 32'h00528333;
        tick();
        checkVal("rst_rf.RD1E", RD1E, 32'h0);
        checkVal("rst_rf.RD2E", RD2E, 32'h0);
        checkVal("rst_rf.RegWriteE", {31'd0, RegWriteE}, 32'd1);

        // addi x1,x0,5
        InstrD = 32'h00500093;
        tick();
        checkControls("addi", 1, 0, 0, 0, 0, 0, 1);
        checkVal("addi.ImmExtE", ImmExtE, 32'd5);
        checkVal("addi.RdE", {27'd0, RdE}, 32'd1);
        checkVal("addi.Rs1E", {27'd0, Rs1E}, 32'd0);

        // Write-through on rs1 and rs2
        InstrD = 32'h002101B3;
        RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'hDEADBEEF;
        tick();
        checkVal("wt.RD1E", RD1E, 32'hDEADBEEF);
        checkVal("wt.RD2E", RD2E, 32'hDEADBEEF);
        checkVal("wt.ALUControlE", {29'd0, ALUControlE}, 32'd0);
        checkVal("wt.ALUSrcE", {31'd0, ALUSrcE}, 32'd0);
        checkVal("wt.RdE", {27'd0, RdE}, 32'd3);

        // Write to x0 discarded, including the bypass
        InstrD = 32'h000001B3; RDW = 5'd0; ResultW = 32'h1234;
        tick();
        checkVal("x0_wt.RD1E", RD1E, 32'h0);
        RegWriteW = 1'b0;
        tick();
        checkVal("x0_rd.RD1E", RD1E, 32'h0);

        // x2 retained in the array, not just bypassed
        InstrD = 32'h002101B3;
        tick();
        checkVal("rf_x2.RD1E", RD1E, 32'hDEADBEEF);

        // beq x1,x2,-4
        InstrD = 32'hFE208EE3;
        tick();
        checkControls("beq", 0, 0, 0, 0, 1, 1, 0);
        checkVal("beq.ImmExtE", ImmExtE, 32'hFFFFFFFC);
        checkVal("beq.Rs1E", {27'd0, Rs1E}, 32'd1);
        checkVal("beq.Rs2E", {27'd0, Rs2E}, 32'd2);

        // jal x1,8
        InstrD = 32'h008000EF;
        tick();
        checkControls("jal", 1, 2, 0, 1, 0, 0, 0);
        checkVal("jal.ImmExtE", ImmExtE, 32'd8);
        checkVal("jal.RdE", {27'd0, RdE}, 32'd1);

        // Flush bubble, then the same lw advances
        InstrD = 32'h0080A203; PCD = 32'h10; PCPlus4D = 32'h14; FlushE = 1'b1;
        tick();
        checkControls("flush", 0, 0, 0, 0, 0, 0, 0);
        checkVal("flush.ImmExtE", ImmExtE, 32'h0);
        checkVal("flush.PCE", PCE, 32'h0);
        checkVal("flush.RdE", {27'd0, RdE}, 32'h0);
        FlushE = 1'b0;
        tick();
        checkControls("lw", 1, 1, 0, 0, 0, 0, 1);
        checkVal("lw.ImmExtE", ImmExtE, 32'd8);
        checkVal("lw.PCE", PCE, 32'h10);
        checkVal("lw.PCPlus4E", PCPlus4E, 32'h14);
        checkVal("lw.RdE", {27'd0, RdE}, 32'd4);

        // sw positive and negative offsets
        InstrD = 32'h0020A423;
        tick();
        checkControls("sw", 0, 0, 1, 0, 0, 0, 1);
        checkVal("sw.ImmExtE", ImmExtE, 32'd8);
        InstrD = 32'hFE20AE23;
        tick();
        checkVal("sw_neg.ImmExtE", ImmExtE, 32'hFFFFFFFC);

        // ALU decode variants
        InstrD = 32'h402083B3; tick();
        checkVal("sub.ALUControlE", {29'd0, ALUControlE}, 32'd1);
        InstrD = 32'h40000093; tick();
        checkVal("addi_b30.ALUControlE", {29'd0, ALUControlE}, 32'd0);
        checkVal("addi_b30.ImmExtE", ImmExtE, 32'h400);
        InstrD = 32'h0020E1B3; tick();
        checkVal("or.ALUControlE", {29'd0, ALUControlE}, 32'd3);
        InstrD = 32'h0020F1B3; tick();
        checkVal("and.ALUControlE", {29'd0, ALUControlE}, 32'd2);
        InstrD = 32'h0020A1B3; tick();
        checkVal("slt.ALUControlE", {29'd0, ALUControlE}, 32'd5);

        // Unknown opcode behaves as a nop
        InstrD = 32'h0000007F; tick();
        checkControls("unk", 0, 0, 0, 0, 0, 0, 0);

        // Reset drops a same-cycle write-back
        rst = 1'b1; RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h99;
        tick();
        rst = 1'b0; RegWriteW = 1'b0;
        InstrD = 32'h000481B3;
        tick();
        checkVal("rst_wr.RD1E", RD1E, 32'h0);
        checkVal("rst_wr.Rs1E", {27'd0, Rs1E}, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
`default_nettype wire
